rv_fetch: RTL

Instruction fetch stage for the pipelined (non-MODE_STAGED) core. It holds the fetch PC, runs a single-outstanding request/ack instruction bus, and buffers returned words in a 2-entry queue (output register + skid) toward decode. It reports word availability to the hazard/control unit, which feeds that unit's i_fetch_bus_ack. It obeys the control unit's fetch stall, and it redirects on the execute-stage branch/jump select.

---
 rtl/rv_fetch.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/rv_fetch.sv
// ---------------------------------------------------------------------------
// rv_fetch -- instruction fetch stage for the pipelined core.
//
// Holds the fetch PC, runs a single-outstanding request/ack instruction bus
// and buffers returned words in a two-entry queue (head register + skid)
// toward decode. Head validity is reported to the hazard/control unit.
//
// Optional build macro: RV_FETCH_BUS_ERR_EN
//   When defined, adds i_bus_err / o_fault and the S_HALT state. An erroring
//   ack pushes a faulted NOP entry and halts fetch until the next redirect.
//   When undefined, the bus is treated as error-free.
//
// Ports:
//   i_clk        clock, all state on the rising edge
//   i_reset      asynchronous active-high reset
//   i_stall      control-unit stall; head entry is not consumed while high
//   i_pc_sel     execute-stage redirect strobe
//   i_pc_target  redirect target, low two bits forced to zero
//   o_bus_req    instruction bus request (registered)
//   o_bus_addr   word address of the outstanding request
//   i_bus_ack    single-cycle ack, i_bus_data valid in the same cycle
//   i_bus_data   returned instruction word
//   i_bus_err    (optional) ack carries a bus error
//   o_fault      (optional) head entry is a faulted fetch
//   o_fetch_ack  head entry valid
//   o_instr      head instruction, NOP_INSTR when no entry is valid
//   o_pc         PC of the head instruction
//   o_pc_p4      o_pc + 4, modulo 2^32
//
// States:
//   state     | meaning
//   S_RESET   | first cycle after reset, no request yet
//   S_RUN     | normal fetch, acked words are queued
//   S_DISCARD | redirect hit a pending request; wait for its ack and drop it
//   S_HALT    | (optional) bus error seen; no requests until a redirect
// ---------------------------------------------------------------------------
module rv_fetch #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_stall,
    input  logic        i_pc_sel,
    input  logic [31:0] i_pc_target,
    output logic        o_bus_req,
    output logic [31:0] o_bus_addr,
    input  logic        i_bus_ack,
    input  logic [31:0] i_bus_data,
`ifdef RV_FETCH_BUS_ERR_EN
    input  logic        i_bus_err,
    output logic        o_fault,
`endif
    output logic        o_fetch_ack,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_p4
);

`ifdef RV_FETCH_BUS_ERR_EN
    typedef enum logic [1:0] {
        S_RESET   = 2'd0,
        S_RUN     = 2'd1,
        S_DISCARD = 2'd2,
        S_HALT    = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_RESET   = 2'd0,
        S_RUN     = 2'd1,
        S_DISCARD = 2'd2
    } state_t;
`endif

    state_t      state, state_next;

    logic [31:0] r_pc, pc_next;
    logic [31:0] r_addr, addr_next;
    logic        r_req, req_next;
    logic [1:0]  r_cnt, cnt_next;

    // queue entry 0 is the head, entry 1 is the skid slot
    logic [31:0] q0_instr, q0_instr_next;
    logic [31:0] q0_pc, q0_pc_next;
    logic        q0_fault, q0_fault_next;
    logic [31:0] q1_instr, q1_instr_next;
    logic [31:0] q1_pc, q1_pc_next;
    logic        q1_fault, q1_fault_next;

    logic        ack_v;
    logic        pending;
    logic        consume;
    logic        capture;
    logic        bus_err;
    logic [1:0]  base;
    logic [31:0] cap_instr;

`ifdef RV_FETCH_BUS_ERR_EN
    assign bus_err = i_bus_err;
`else
    assign bus_err = 1'b0;
`endif

    always_comb begin
        state_next    = state;
        pc_next       = r_pc;
        cnt_next      = r_cnt;
        q0_instr_next = q0_instr;
        q0_pc_next    = q0_pc;
        q0_fault_next = q0_fault;
        q1_instr_next = q1_instr;
        q1_pc_next    = q1_pc;
        q1_fault_next = q1_fault;
        base          = r_cnt;

        // acks only count against a live request
        ack_v     = r_req & i_bus_ack;
        pending   = r_req & ~i_bus_ack;
        consume   = (r_cnt != 2'd0) & ~i_stall;
        capture   = (state == S_RUN) & ack_v & ~i_pc_sel;
        cap_instr = bus_err ? NOP_INSTR : i_bus_data;

        case (state)
            S_RESET: begin
                state_next = S_RUN;
            end
            S_RUN: begin
                if (i_pc_sel) begin
                    // the in-flight address can't be changed, so wait it out
                    if (pending) begin
                        state_next = S_DISCARD;
                    end
                end else if (capture && bus_err) begin
`ifdef RV_FETCH_BUS_ERR_EN
                    state_next = S_HALT;
`endif
                end
            end
            S_DISCARD: begin
                if (ack_v) begin
                    state_next = S_RUN;
                end
            end
`ifdef RV_FETCH_BUS_ERR_EN
            S_HALT: begin
                if (i_pc_sel) begin
                    state_next = S_RUN;
                end
            end
`endif
            default: begin
                state_next = S_RUN;
            end
        endcase

        if (i_pc_sel) begin
            pc_next = i_pc_target & 32'hFFFF_FFFC;
        end else if (capture && !bus_err) begin
            pc_next = r_pc + 32'd4;
        end

        if (i_pc_sel) begin
            cnt_next = 2'd0;
        end else begin
            if (consume) begin
                base          = r_cnt - 2'd1;
                q0_instr_next = q1_instr;
                q0_pc_next    = q1_pc;
                q0_fault_next = q1_fault;
            end
            // new word lands in the first free slot after any pop
            if (capture) begin
                if (base == 2'd0) begin
                    q0_instr_next = cap_instr;
                    q0_pc_next    = r_pc;
                    q0_fault_next = bus_err;
                end else begin
                    q1_instr_next = cap_instr;
                    q1_pc_next    = r_pc;
                    q1_fault_next = bus_err;
                end
            end
            cnt_next = base + {1'b0, capture};
        end

        // a pending request keeps its address; otherwise track the fetch PC
        req_next  = pending |
                    (((state_next == S_RUN) || (state_next == S_DISCARD)) &&
                     (cnt_next <= 2'd1));
        addr_next = pending ? r_addr : pc_next;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state    <= S_RESET;
            r_pc     <= RESET_VECTOR;
            r_addr   <= RESET_VECTOR;
            r_req    <= 1'b0;
            r_cnt    <= 2'd0;
            q0_instr <= NOP_INSTR;
            q0_pc    <= RESET_VECTOR;
            q0_fault <= 1'b0;
            q1_instr <= NOP_INSTR;
            q1_pc    <= RESET_VECTOR;
            q1_fault <= 1'b0;
        end else begin
            state    <= state_next;
            r_pc     <= pc_next;
            r_addr   <= addr_next;
            r_req    <= req_next;
            r_cnt    <= cnt_next;
            q0_instr <= q0_instr_next;
            q0_pc    <= q0_pc_next;
            q0_fault <= q0_fault_next;
            q1_instr <= q1_instr_next;
            q1_pc    <= q1_pc_next;
            q1_fault <= q1_fault_next;
        end
    end

    // outputs decode registers only; no combinational path from i_stall
    assign o_bus_req   = r_req;
    assign o_bus_addr  = r_addr;
    assign o_fetch_ack = (r_cnt != 2'd0);
    assign o_instr     = (r_cnt != 2'd0) ? q0_instr : NOP_INSTR;
    assign o_pc        = q0_pc;
    assign o_pc_p4     = q0_pc + 32'd4;

`ifdef RV_FETCH_BUS_ERR_EN
    assign o_fault = (r_cnt != 2'd0) & q0_fault;
`else
    // fault flags only matter when bus errors are reported
    logic unused_fault;
    assign unused_fault = q0_fault ^ q1_fault;
`endif

endmodule
